// File: rtl/button_conditioner.sv
// button_conditioner: N independent push-button channels. Each raw input is
// synchronised, debounced symmetrically on both edges, and classified into a
// stable level plus single-cycle press, release, long-press (hold) and
// auto-repeat events.
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset      asynchronous active-high reset, clears all state
//   button_i   [N] raw asynchronous button inputs, active-high
//   repeat_en  [N] per-channel auto-repeat enable, sampled every cycle
//   level_o    [N] debounced level
//   press_o    [N] one-cycle pulse on level 0->1
//   release_o  [N] one-cycle pulse on level 1->0
//   hold_o     [N] one-cycle pulse when the long-press threshold is reached
//   repeat_o   [N] one-cycle auto-repeat pulses while in long press
module button_conditioner #(
  parameter int unsigned N             = 4,
  parameter int unsigned DEB_CYCLES    = 1000000,  // >= 2
  parameter int unsigned HOLD_CYCLES   = 50000000, // >= 2
  parameter int unsigned REPEAT_CYCLES = 10000000  // >= 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] button_i,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] level_o,
  output logic [N-1:0] press_o,
  output logic [N-1:0] release_o,
  output logic [N-1:0] hold_o,
  output logic [N-1:0] repeat_o
);

  // Counters only ever hold values up to (threshold - 1).
  localparam int unsigned HoldRepMax =
      (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int HW = $clog2(HoldRepMax);

  localparam logic [DW-1:0] DebMax  = DW'(DEB_CYCLES - 1);
  localparam logic [HW-1:0] HoldMax = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] RepMax  = HW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    StRel,
    StHeld,
    StLong
  } hold_state_e;

  for (genvar g = 0; g < N; g++) begin : g_chan
    logic [1:0]    sync_q;
    logic          s;
    logic          level_q, level_d;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    hold_state_e   state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          hold_q, hold_d;
    logic          repeat_q, repeat_d;

    assign s = sync_q[1];

    // Debounce: level follows s only after DEB_CYCLES consecutive mismatches.
    always_comb begin
      level_d   = level_q;
      dcnt_d    = '0;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (s != level_q) begin
        if (dcnt_q == DebMax) begin
          level_d   = s;
          press_d   = s;
          release_d = ~s;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    // Hold / repeat FSM. It reacts to the level change in the same cycle the
    // edge event is issued, so hold lands exactly HOLD_CYCLES after press.
    // A release takes priority over any threshold hit in the same cycle.
    always_comb begin
      state_d  = state_q;
      hcnt_d   = hcnt_q;
      hold_d   = 1'b0;
      repeat_d = 1'b0;
      if (release_d) begin
        state_d = StRel;
        hcnt_d  = '0;
      end else begin
        case (state_q)
          StRel: begin
            if (press_d) begin
              state_d = StHeld;
              hcnt_d  = '0;
            end
          end
          StHeld: begin
            if (hcnt_q == HoldMax) begin
              hold_d  = 1'b1;
              state_d = StLong;
              hcnt_d  = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          StLong: begin
            if (!repeat_en[g]) begin
              hcnt_d = '0;
            end else if (hcnt_q == RepMax) begin
              repeat_d = 1'b1;
              hcnt_d   = '0;
            end else begin
              hcnt_d = hcnt_q + 1'b1;
            end
          end
          default: begin
            state_d = StRel;
            hcnt_d  = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync_q    <= '0;
        level_q   <= 1'b0;
        dcnt_q    <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        state_q   <= StRel;
        hcnt_q    <= '0;
        hold_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        sync_q    <= {sync_q[0], button_i[g]};
        level_q   <= level_d;
        dcnt_q    <= dcnt_d;
        press_q   <= press_d;
        release_q <= release_d;
        state_q   <= state_d;
        hcnt_q    <= hcnt_d;
        hold_q    <= hold_d;
        repeat_q  <= repeat_d;
      end
    end

    assign level_o[g]   = level_q;
    assign press_o[g]   = press_q;
    assign release_o[g] = release_q;
    assign hold_o[g]    = hold_q;
    assign repeat_o[g]  = repeat_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner. A reference model computes, at
// every rising edge, the expected output word from the behavioural rules
// (two-edge input delay, run-length debounce, elapsed-time hold, enabled-run
// repeat) and queues it; an independent monitor pops and compares on the
// falling edge.
module tb_button_conditioner;

  localparam int N    = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int REP  = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] button_i = '0;
  logic [N-1:0] repeat_en = '0;
  logic [N-1:0] level_o, press_o, release_o, hold_o, repeat_o;

  button_conditioner #(
    .N             (N),
    .DEB_CYCLES    (DEB),
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .button_i  (button_i),
    .repeat_en (repeat_en),
    .level_o   (level_o),
    .press_o   (press_o),
    .release_o (release_o),
    .hold_o    (hold_o),
    .repeat_o  (repeat_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int cyc    = 0;

  logic [5*N-1:0] exp_q[$];

  // Reference model state
  logic [2:0] m_hist   [N];  // [0] sampled this edge, [2] two edges ago
  logic       m_level  [N];
  int         m_run    [N];  // consecutive edges the delayed input differed from level
  int         m_phase  [N];  // 0 released, 1 pressed, 2 long press
  int         m_press_at[N];
  int         m_en_run [N];  // consecutive enabled edges since hold/last repeat

  initial begin
    forever begin
      @(posedge clk);
      begin
        logic [N-1:0] lv, pr, rl, ho, rp;
        logic         s;
        lv = '0; pr = '0; rl = '0; ho = '0; rp = '0;
        cyc = cyc + 1;
        for (int c = 0; c < N; c++) begin
          if (reset) begin
            m_hist[c]   = '0;
            m_level[c]  = 1'b0;
            m_run[c]    = 0;
            m_phase[c]  = 0;
            m_en_run[c] = 0;
          end else begin
            m_hist[c] = {m_hist[c][1:0], button_i[c]};
            s = m_hist[c][2];
            if (s != m_level[c]) begin
              m_run[c] = m_run[c] + 1;
              if (m_run[c] == DEB) begin
                m_level[c] = s;
                m_run[c]   = 0;
                if (s) pr[c] = 1'b1;
                else   rl[c] = 1'b1;
              end
            end else begin
              m_run[c] = 0;
            end
            if (rl[c]) begin
              m_phase[c] = 0;
            end else if (pr[c]) begin
              m_phase[c]    = 1;
              m_press_at[c] = cyc;
            end else if (m_phase[c] == 1) begin
              if (cyc - m_press_at[c] == HOLD) begin
                ho[c]       = 1'b1;
                m_phase[c]  = 2;
                m_en_run[c] = 0;
              end
            end else if (m_phase[c] == 2) begin
              if (repeat_en[c]) begin
                m_en_run[c] = m_en_run[c] + 1;
                if (m_en_run[c] == REP) begin
                  rp[c]       = 1'b1;
                  m_en_run[c] = 0;
                end
              end else begin
                m_en_run[c] = 0;
              end
            end
            lv[c] = m_level[c];
          end
        end
        exp_q.push_back({rp, ho, rl, pr, lv});
      end
    end
  end

  // Monitor
  initial begin
    logic [5*N-1:0] got, e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = {repeat_o, hold_o, release_o, press_o, level_o};
      checks = checks + 1;
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard_empty cycle %0d got rep/hold/rel/press/lvl=%b nothing expected",
                 cyc, got);
      end else begin
        e = exp_q.pop_front();
        if (got === e) passed = passed + 1;
        else $display("FAIL outputs cycle %0d got rep/hold/rel/press/lvl=%b required %b",
                      cyc, got, e);
      end
    end
  end

  // Hold inputs for n rising edges; called and returns at negedge + 1.
  task automatic drive(input logic [N-1:0] b, input logic [N-1:0] re, input int n);
    button_i  = b;
    repeat_en = re;
    repeat (n) @(negedge clk);
    #1;
  endtask

  logic [N-1:0] rb, rre;
  int           rem[N];

  initial begin
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;

    // Clean press on ch0: 9 cycles high then low
    drive(2'b01, 2'b00, 9);
    drive(2'b00, 2'b00, 12);

    // Bounce: toggle every 3 cycles for 24 cycles, then stay high
    for (int i = 0; i < 8; i++) drive((i % 2 == 0) ? 2'b01 : 2'b00, 2'b00, 3);
    drive(2'b01, 2'b00, 20);
    drive(2'b00, 2'b00, 12);

    // Long press with auto-repeat, held 30 cycles past press
    drive(2'b01, 2'b01, 6 + 30);
    drive(2'b00, 2'b01, 12);

    // Long press with repeat disabled, then enabled mid-LONG
    drive(2'b01, 2'b00, 6 + 10 + 8);
    drive(2'b01, 2'b01, 10);
    drive(2'b00, 2'b00, 12);

    // Two channels pressed one cycle apart
    drive(2'b01, 2'b00, 1);
    drive(2'b11, 2'b00, 20);
    drive(2'b00, 2'b00, 12);

    // Release landing on the hold edge: release and hold thresholds coincide
    drive(2'b01, 2'b00, 10);
    drive(2'b00, 2'b00, 12);

    // Reset during LONG with the button still held
    drive(2'b01, 2'b01, 25);
    reset = 1'b1;
    #1;
    checks = checks + 1;
    if ({repeat_o, hold_o, release_o, press_o, level_o} === '0) passed = passed + 1;
    else $display("FAIL reset_immediate got rep/hold/rel/press/lvl=%b required all zero",
                  {repeat_o, hold_o, release_o, press_o, level_o});
    @(negedge clk);
    #1 reset = 1'b0;
    drive(2'b01, 2'b01, 20);
    drive(2'b00, 2'b00, 12);

    // Randomised segments with occasional reset pulses
    rb  = '0;
    rre = '0;
    for (int c = 0; c < N; c++) rem[c] = 1;
    for (int k = 0; k < 1500; k++) begin
      for (int c = 0; c < N; c++) begin
        rem[c] = rem[c] - 1;
        if (rem[c] == 0) begin
          rb[c]  = ~rb[c];
          rem[c] = ($urandom_range(3, 0) == 0) ? int'($urandom_range(5, 1))
                                               : int'($urandom_range(40, 4));
        end
        if ($urandom_range(19, 0) == 0) rre[c] = ~rre[c];
      end
      reset = ($urandom_range(299, 0) == 0);
      drive(rb, rre, 1);
    end
    reset = 1'b0;
    drive(2'b00, 2'b00, 12);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
